// File: rtl/cu_seq_pkg.sv
// Shared encodings for the control-unit microsequencer: next-address ops,
// instruction opcodes and the microroutine entry points they dispatch to.
package cu_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_HOLD     = 3'd0,
    SEQ_INC      = 3'd1,
    SEQ_DISPATCH = 3'd2,
    SEQ_FETCH    = 3'd3,
    SEQ_BRANCH   = 3'd4,
    SEQ_CALL     = 3'd5,
    SEQ_RET      = 3'd6,
    SEQ_JUMP     = 3'd7
  } seq_op_e;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_JGE   = 8'h06;
  localparam logic [7:0] OP_JMP   = 8'h07;
  localparam logic [7:0] OP_HALT  = 8'h08;
  localparam logic [7:0] OP_AND   = 8'h0A;
  localparam logic [7:0] OP_OR    = 8'h0B;
  localparam logic [7:0] OP_XOR   = 8'h0C;
  localparam logic [7:0] OP_SHL   = 8'h0D;
  localparam logic [7:0] OP_SHR   = 8'h0E;

  localparam logic [7:0] UA_LOAD  = 8'h04;
  localparam logic [7:0] UA_STORE = 8'h07;
  localparam logic [7:0] UA_ADD   = 8'h0B;
  localparam logic [7:0] UA_SUB   = 8'h0F;
  localparam logic [7:0] UA_JGE   = 8'h13;
  localparam logic [7:0] UA_JMP   = 8'h15;
  localparam logic [7:0] UA_HALT  = 8'h16;
  localparam logic [7:0] UA_AND   = 8'h1E;
  localparam logic [7:0] UA_OR    = 8'h22;
  localparam logic [7:0] UA_XOR   = 8'h26;
  localparam logic [7:0] UA_SHL   = 8'h2A;
  localparam logic [7:0] UA_SHR   = 8'h2D;

endpackage

// File: rtl/cu_dispatch_map.sv
// Opcode to microroutine start address; purely combinational, no stall path.
// valid is low for opcodes with no microroutine.
module cu_dispatch_map
  import cu_seq_pkg::*;
#(
  parameter int AW  = 8,
  parameter int OPW = 8
) (
  input  logic [OPW-1:0] opcode,
  output logic [AW-1:0]  start_addr,
  output logic           valid
);

  always_comb begin
    start_addr = '0;
    valid      = 1'b1;
    case (opcode)
      OPW'(OP_LOAD):  start_addr = AW'(UA_LOAD);
      OPW'(OP_STORE): start_addr = AW'(UA_STORE);
      OPW'(OP_ADD):   start_addr = AW'(UA_ADD);
      OPW'(OP_SUB):   start_addr = AW'(UA_SUB);
      OPW'(OP_JGE):   start_addr = AW'(UA_JGE);
      OPW'(OP_JMP):   start_addr = AW'(UA_JMP);
      OPW'(OP_HALT):  start_addr = AW'(UA_HALT);
      OPW'(OP_AND):   start_addr = AW'(UA_AND);
      OPW'(OP_OR):    start_addr = AW'(UA_OR);
      OPW'(OP_XOR):   start_addr = AW'(UA_XOR);
      OPW'(OP_SHL):   start_addr = AW'(UA_SHL);
      OPW'(OP_SHR):   start_addr = AW'(UA_SHR);
      default:        valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/cu_microsequencer.sv
// Microprogram sequencer: next micro-address selection with a return stack.
// One cycle from seq_op to car_data; stall freezes every register.
module cu_microsequencer
  import cu_seq_pkg::*;
#(
  parameter int             AW         = 8,
  parameter int             OPW        = 8,
  parameter int             NCOND      = 4,
  parameter int             DEPTH      = 4,
  parameter logic [AW-1:0]  FETCH_ADDR = '0,
  localparam int            CSW        = (NCOND > 1) ? $clog2(NCOND) : 1,
  localparam int            SPW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       seq_op,
  input  logic [CSW-1:0]   cond_sel,
  input  logic             cond_inv,
  input  logic [AW-1:0]    branch_addr,
  input  logic [OPW-1:0]   opcode,
  input  logic [NCOND-1:0] cond_flags,
  output logic [AW-1:0]    car_data,
  output logic [SPW-1:0]   sp,
  output logic             illegal_op,
  output logic             stk_ovf,
  output logic             stk_unf
);

  localparam int SIDX = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]   stack_q [DEPTH];
  logic [AW-1:0]   car_n, car_inc, map_addr;
  logic [SPW-1:0]  sp_n;
  logic [SIDX-1:0] push_idx, top_idx;
  logic            map_valid, taken, push;
  logic            set_ill, set_ovf, set_unf;

  cu_dispatch_map #(.AW(AW), .OPW(OPW)) u_map (
    .opcode     (opcode),
    .start_addr (map_addr),
    .valid      (map_valid)
  );

  assign car_inc  = car_data + AW'(1);
  assign push_idx = SIDX'(sp);
  assign top_idx  = SIDX'(sp - SPW'(1));
  // Out-of-range flag selects never branch, even when inverted.
  assign taken    = (int'(cond_sel) < NCOND) && (cond_flags[cond_sel] ^ cond_inv);

  always_comb begin
    car_n   = car_data;
    sp_n    = sp;
    push    = 1'b0;
    set_ill = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    case (seq_op_e'(seq_op))
      SEQ_HOLD: car_n = car_data;
      SEQ_INC:  car_n = car_inc;
      SEQ_DISPATCH: begin
        car_n   = map_valid ? map_addr : FETCH_ADDR;
        set_ill = !map_valid;
      end
      SEQ_FETCH: begin
        car_n = FETCH_ADDR;
        sp_n  = '0;
      end
      SEQ_BRANCH: car_n = taken ? branch_addr : car_inc;
      SEQ_CALL: begin
        if (sp < SPW'(DEPTH)) begin
          push  = 1'b1;
          sp_n  = sp + SPW'(1);
          car_n = branch_addr;
        end else begin
          set_ovf = 1'b1;
          car_n   = FETCH_ADDR;
        end
      end
      SEQ_RET: begin
        if (sp != '0) begin
          car_n = stack_q[top_idx];
          sp_n  = sp - SPW'(1);
        end else begin
          set_unf = 1'b1;
          car_n   = FETCH_ADDR;
        end
      end
      SEQ_JUMP: car_n = branch_addr;
      default:  car_n = car_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_data   <= FETCH_ADDR;
      sp         <= '0;
      illegal_op <= 1'b0;
      stk_ovf    <= 1'b0;
      stk_unf    <= 1'b0;
    end else if (!stall) begin
      car_data   <= car_n;
      sp         <= sp_n;
      illegal_op <= illegal_op | set_ill;
      stk_ovf    <= stk_ovf | set_ovf;
      stk_unf    <= stk_unf | set_unf;
    end
  end

  // Entries need no reset; sp alone decides what is live.
  always_ff @(posedge clk) begin
    if (!rst && !stall && push) begin
      stack_q[push_idx] <= car_inc;
    end
  end

endmodule

// File: tb/tb_cu_microsequencer.sv
// Directed bench for cu_microsequencer with hand-computed expectations.
module tb_cu_microsequencer;
  import cu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [2:0] seq_op;
  logic [1:0] cond_sel;
  logic       cond_inv;
  logic [7:0] branch_addr;
  logic [7:0] opcode;
  logic [3:0] cond_flags;
  logic [7:0] car_data;
  logic [2:0] sp;
  logic       illegal_op, stk_ovf, stk_unf;

  int tests_run = 0;
  int tests_failed = 0;

  cu_microsequencer #(.AW(8), .OPW(8), .NCOND(4), .DEPTH(4), .FETCH_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst), .stall(stall), .seq_op(seq_op), .cond_sel(cond_sel),
    .cond_inv(cond_inv), .branch_addr(branch_addr), .opcode(opcode),
    .cond_flags(cond_flags), .car_data(car_data), .sp(sp),
    .illegal_op(illegal_op), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  // Drive one microword, then sample 1 time unit after the active edge.
  task automatic step(input logic [2:0] op, input logic [7:0] ba);
    seq_op = op;
    branch_addr = ba;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if (car_data !== 8'h00 || sp !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state car=%h sp=%0d required car=00 sp=0", car_data, sp);
    end
    tests_run++;
    if ({illegal_op, stk_ovf, stk_unf} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b required=000", {illegal_op, stk_ovf, stk_unf});
    end
  endtask

  task automatic test_inc();
    logic [7:0] exp_car [3];
    exp_car[0] = 8'h01; exp_car[1] = 8'h02; exp_car[2] = 8'h03;
    for (int i = 0; i < 3; i++) begin
      step(SEQ_INC, 8'h00);
      tests_run++;
      if (car_data !== exp_car[i]) begin
        tests_failed++;
        $display("FAIL inc_%0d car=%h required=%h", i, car_data, exp_car[i]);
      end
    end
    step(SEQ_HOLD, 8'h00);
    tests_run++;
    if (car_data !== 8'h03) begin
      tests_failed++;
      $display("FAIL hold car=%h required=03", car_data);
    end
    step(SEQ_JUMP, 8'hFF);
    step(SEQ_INC, 8'h00);
    tests_run++;
    if (car_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL inc_wrap car=%h required=00", car_data);
    end
  endtask

  task automatic test_dispatch();
    opcode = 8'h03;
    step(SEQ_DISPATCH, 8'h00);
    tests_run++;
    if (car_data !== 8'h0B || illegal_op !== 1'b0) begin
      tests_failed++;
      $display("FAIL dispatch_03 car=%h ill=%b required car=0B ill=0", car_data, illegal_op);
    end
    opcode = 8'h0E;
    step(SEQ_DISPATCH, 8'h00);
    tests_run++;
    if (car_data !== 8'h2D) begin
      tests_failed++;
      $display("FAIL dispatch_0E car=%h required=2D", car_data);
    end
    opcode = 8'h09;
    step(SEQ_DISPATCH, 8'h00);
    tests_run++;
    if (car_data !== 8'h00 || illegal_op !== 1'b1) begin
      tests_failed++;
      $display("FAIL dispatch_illegal car=%h ill=%b required car=00 ill=1", car_data, illegal_op);
    end
    opcode = 8'h01;
    step(SEQ_DISPATCH, 8'h00);
    step(SEQ_INC, 8'h00);
    tests_run++;
    if (car_data !== 8'h05 || illegal_op !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_sticky car=%h ill=%b required car=05 ill=1", car_data, illegal_op);
    end
  endtask

  task automatic test_branch();
    // {cond_sel, cond_inv, cond_flags, branch_addr, expected car}
    logic [1:0] sel_v [6];
    logic       inv_v [6];
    logic [3:0] flg_v [6];
    logic [7:0] ba_v  [6];
    logic [7:0] exp_v [6];
    sel_v[0] = 2'd0; inv_v[0] = 1'b0; flg_v[0] = 4'b0001; ba_v[0] = 8'h13; exp_v[0] = 8'h13;
    sel_v[1] = 2'd0; inv_v[1] = 1'b0; flg_v[1] = 4'b1110; ba_v[1] = 8'h30; exp_v[1] = 8'h13;
    sel_v[2] = 2'd0; inv_v[2] = 1'b1; flg_v[2] = 4'b0000; ba_v[2] = 8'h40; exp_v[2] = 8'h40;
    sel_v[3] = 2'd0; inv_v[3] = 1'b1; flg_v[3] = 4'b0001; ba_v[3] = 8'h40; exp_v[3] = 8'h13;
    sel_v[4] = 2'd3; inv_v[4] = 1'b0; flg_v[4] = 4'b1000; ba_v[4] = 8'h77; exp_v[4] = 8'h77;
    sel_v[5] = 2'd2; inv_v[5] = 1'b0; flg_v[5] = 4'b1011; ba_v[5] = 8'h77; exp_v[5] = 8'h13;
    for (int i = 0; i < 6; i++) begin
      step(SEQ_JUMP, 8'h12);
      cond_sel = sel_v[i]; cond_inv = inv_v[i]; cond_flags = flg_v[i];
      step(SEQ_BRANCH, ba_v[i]);
      tests_run++;
      if (car_data !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL branch_%0d car=%h required=%h", i, car_data, exp_v[i]);
      end
    end
    cond_sel = 2'd0; cond_inv = 1'b0; cond_flags = 4'b0000;
  endtask

  task automatic test_call_ret();
    logic [7:0] ret_v [4];
    ret_v[0] = 8'h41; ret_v[1] = 8'h31; ret_v[2] = 8'h21; ret_v[3] = 8'h11;
    for (int i = 1; i <= 4; i++) begin
      step(SEQ_JUMP, 8'(i * 16));
      step(SEQ_CALL, 8'h50);
      tests_run++;
      if (car_data !== 8'h50 || sp !== 3'(i)) begin
        tests_failed++;
        $display("FAIL call_%0d car=%h sp=%0d required car=50 sp=%0d", i, car_data, sp, i);
      end
    end
    step(SEQ_CALL, 8'h60);
    tests_run++;
    if (car_data !== 8'h00 || sp !== 3'd4 || stk_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL call_overflow car=%h sp=%0d ovf=%b required car=00 sp=4 ovf=1", car_data, sp, stk_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      step(SEQ_RET, 8'h00);
      tests_run++;
      if (car_data !== ret_v[i] || sp !== 3'(3 - i)) begin
        tests_failed++;
        $display("FAIL ret_%0d car=%h sp=%0d required car=%h sp=%0d", i, car_data, sp, ret_v[i], 3 - i);
      end
    end
    tests_run++;
    if (stk_unf !== 1'b0 || stk_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL flags_before_unf unf=%b ovf=%b required unf=0 ovf=1", stk_unf, stk_ovf);
    end
    step(SEQ_RET, 8'h00);
    tests_run++;
    if (car_data !== 8'h00 || sp !== 3'd0 || stk_unf !== 1'b1) begin
      tests_failed++;
      $display("FAIL ret_underflow car=%h sp=%0d unf=%b required car=00 sp=0 unf=1", car_data, sp, stk_unf);
    end
    // Return address FF+1 wraps to 00.
    step(SEQ_JUMP, 8'hFF);
    step(SEQ_CALL, 8'h70);
    step(SEQ_RET, 8'h00);
    tests_run++;
    if (car_data !== 8'h00 || sp !== 3'd0) begin
      tests_failed++;
      $display("FAIL ret_wrap car=%h sp=%0d required car=00 sp=0", car_data, sp);
    end
  endtask

  task automatic test_fetch();
    step(SEQ_JUMP, 8'h08);
    step(SEQ_CALL, 8'h50);
    step(SEQ_CALL, 8'h60);
    step(SEQ_FETCH, 8'h33);
    tests_run++;
    if (car_data !== 8'h00 || sp !== 3'd0) begin
      tests_failed++;
      $display("FAIL fetch car=%h sp=%0d required car=00 sp=0", car_data, sp);
    end
  endtask

  task automatic test_stall();
    step(SEQ_JUMP, 8'h05);
    step(SEQ_CALL, 8'h09);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(SEQ_JUMP, 8'h2A);
      tests_run++;
      if (car_data !== 8'h09 || sp !== 3'd1) begin
        tests_failed++;
        $display("FAIL stall_%0d car=%h sp=%0d required car=09 sp=1", i, car_data, sp);
      end
    end
    step(SEQ_RET, 8'h00);
    tests_run++;
    if (car_data !== 8'h09 || sp !== 3'd1) begin
      tests_failed++;
      $display("FAIL stall_ret car=%h sp=%0d required car=09 sp=1", car_data, sp);
    end
    stall = 1'b0;
    step(SEQ_JUMP, 8'h2A);
    tests_run++;
    if (car_data !== 8'h2A) begin
      tests_failed++;
      $display("FAIL stall_release car=%h required=2A", car_data);
    end
    step(SEQ_FETCH, 8'h00);
  endtask

  task automatic test_async_reset();
    step(SEQ_JUMP, 8'h10);
    step(SEQ_CALL, 8'h50);
    step(SEQ_CALL, 8'h60);
    tests_run++;
    if (sp !== 3'd2 || car_data !== 8'h60) begin
      tests_failed++;
      $display("FAIL pre_reset car=%h sp=%0d required car=60 sp=2", car_data, sp);
    end
    seq_op = SEQ_RET;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (car_data !== 8'h00 || sp !== 3'd0 || {illegal_op, stk_ovf, stk_unf} !== 3'b000) begin
      tests_failed++;
      $display("FAIL async_reset car=%h sp=%0d flags=%b required car=00 sp=0 flags=000",
               car_data, sp, {illegal_op, stk_ovf, stk_unf});
    end
    #3;
    rst = 1'b0;
    step(SEQ_INC, 8'h00);
    tests_run++;
    if (car_data !== 8'h01 || sp !== 3'd0) begin
      tests_failed++;
      $display("FAIL post_reset car=%h sp=%0d required car=01 sp=0", car_data, sp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; seq_op = SEQ_HOLD; cond_sel = 2'd0; cond_inv = 1'b0;
    branch_addr = 8'h00; opcode = 8'h00; cond_flags = 4'b0000;
    #12;
    test_reset();
    rst = 1'b0;
    test_inc();
    test_dispatch();
    test_branch();
    test_call_ret();
    test_fetch();
    test_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
